multi_button_control: RTL and testbench

- Parametrised successor to the single-button vote qualifier: debounces NUM_BUTTONS independent candidate buttons and issues at most one one-hot, single-cycle vote pulse per qualified press.
- Rejects simultaneous presses as a conflict.
- Enforces a post-vote lockout window.
- Sits between the raw candidate buttons and the vote logger/tally.

---
 rtl/multi_button_control.sv | 129 ++++++++++++
 tb/tb_multi_button_control.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multi_button_control.sv
// Debounced multi-button vote qualifier with conflict rejection and post-vote lockout.
// Define BUTTON_SYNC_EN to add a 2-flop synchroniser on every button input.
module multi_button_control #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 10,
    parameter int LOCKOUT_CYCLES  = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NUM_BUTTONS-1:0]         button,
    input  logic                           enable,
    output logic [NUM_BUTTONS-1:0]         valid_vote,
    output logic [$clog2(NUM_BUTTONS)-1:0] vote_id,
    output logic                           conflict,
    output logic                           busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam int IW = $clog2(NUM_BUTTONS);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_QUAL = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LD  = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic {IDLE, LOCKOUT} state_t;

    state_t                 state, state_next;
    logic [LW-1:0]          lock_cnt, lock_next;
    logic [CW-1:0]          count [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] sampled;
    logic [NUM_BUTTONS-1:0] qual;
    logic [IW-1:0]          qual_idx;
    logic [NUM_BUTTONS-1:0] vote_next;
    logic [IW-1:0]          id_next;
    logic                   conflict_next;

`ifdef BUTTON_SYNC_EN
    logic [NUM_BUTTONS-1:0] sync1, sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    assign sampled = sync2;
`else
    assign sampled = button;
`endif

    // Saturating counters: a held button qualifies exactly once per press
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BUTTONS; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                if (!sampled[i])
                    count[i] <= '0;
                else if (count[i] < CNT_MAX)
                    count[i] <= count[i] + CW'(1);
            end
        end
    end

    always_comb begin
        qual     = '0;
        qual_idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            qual[i] = sampled[i] && (count[i] == CNT_QUAL);
            if (qual[i]) qual_idx = IW'(i);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            valid_vote <= '0;
            vote_id    <= '0;
            conflict   <= 1'b0;
        end else begin
            state      <= state_next;
            lock_cnt   <= lock_next;
            valid_vote <= vote_next;
            vote_id    <= id_next;
            conflict   <= conflict_next;
        end
    end

    always_comb begin
        state_next = state;
        lock_next  = lock_cnt;
        unique case (state)
            IDLE: begin
                if (enable && (|qual)) begin
                    state_next = LOCKOUT;
                    lock_next  = LOCK_LD;
                end
            end
            LOCKOUT: begin
                if (lock_cnt == '0)
                    state_next = IDLE;
                else
                    lock_next = lock_cnt - LW'(1);
            end
        endcase
    end

    always_comb begin
        vote_next     = '0;
        id_next       = vote_id;
        conflict_next = 1'b0;
        if (state == IDLE && enable && (|qual)) begin
            if ($onehot(qual)) begin
                vote_next = qual;
                id_next   = qual_idx;
            end else begin
                conflict_next = 1'b1;
            end
        end
    end

    assign busy = (state == LOCKOUT);

endmodule

// File: tb/tb_multi_button_control.sv
// Randomized and directed bench for multi_button_control against a
// run-length based vote model.
module tb_multi_button_control;

    localparam int N = 4;
    localparam int D = 10;
    localparam int L = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] button = '0;
    logic         enable = 1'b0;
    logic [N-1:0] valid_vote;
    logic [1:0]   vote_id;
    logic         conflict;
    logic         busy;

    multi_button_control #(
        .NUM_BUTTONS(N),
        .DEBOUNCE_CYCLES(D),
        .LOCKOUT_CYCLES(L)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .button(button),
        .enable(enable),
        .valid_vote(valid_vote),
        .vote_id(vote_id),
        .conflict(conflict),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // model: consecutive-high run per channel, remaining busy cycles
    int           run [N];
    int           busy_left;
    logic [N-1:0] m_vote;
    int           m_id;
    bit           m_conf;
    logic [N-1:0] s1, s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) run[i] = 0;
        busy_left = 0;
        m_vote = '0;
        m_id = 0;
        m_conf = 0;
        s1 = '0;
        s2 = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0] seen;
        logic [N-1:0] q;
        int nq;
        int last;
`ifdef BUTTON_SYNC_EN
        seen = s2;
        s2 = s1;
        s1 = button;
`else
        seen = button;
`endif
        q = '0;
        nq = 0;
        last = 0;
        for (int i = 0; i < N; i++) begin
            if (seen[i] && run[i] == D - 1) begin
                q[i] = 1'b1;
                nq++;
                last = i;
            end
            run[i] = seen[i] ? ((run[i] < D) ? run[i] + 1 : run[i]) : 0;
        end
        m_vote = '0;
        m_conf = 0;
        if (busy_left > 0) begin
            busy_left--;
        end else if (enable && nq == 1) begin
            m_vote = q;
            m_id = last;
            busy_left = L;
        end else if (enable && nq > 1) begin
            m_conf = 1;
            busy_left = L;
        end
    endtask

    task automatic compare_all();
        check("valid_vote", 32'(valid_vote), 32'(m_vote));
        check("vote_id", 32'(vote_id), 32'(m_id));
        check("conflict", 32'(conflict), 32'(m_conf));
        check("busy", 32'(busy), 32'(busy_left > 0));
    endtask

    task automatic step(input logic [N-1:0] b, input logic e);
        @(negedge clock);
        button = b;
        enable = e;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        repeat (12) step(4'b0010, 1'b1);
        repeat (20) step(4'b0000, 1'b1);

        repeat (9) step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        repeat (10) step(4'b0001, 1'b1);
        repeat (20) step(4'b0000, 1'b1);

        repeat (10) step(4'b0101, 1'b1);
        repeat (20) step(4'b0000, 1'b1);

        repeat (10) step(4'b0100, 1'b1);
        repeat (20) step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        repeat (10) step(4'b1000, 1'b1);
        repeat (20) step(4'b0000, 1'b1);

        repeat (10) step(4'b0010, 1'b0);
        repeat (5) step(4'b0000, 1'b1);

        repeat (10) step(4'b0001, 1'b1);
        repeat (3) step(4'b0000, 1'b0);
        do_reset();
        repeat (12) step(4'b0001, 1'b1);
        repeat (20) step(4'b0000, 1'b1);

        // boundary: press lands on the first idle cycle after lockout
        repeat (10) step(4'b0001, 1'b1);
        repeat (L - D + 1) step(4'b0000, 1'b1);
        repeat (12) step(4'b0010, 1'b1);
        repeat (20) step(4'b0000, 1'b1);

        begin
            logic [N-1:0] b;
            b = '0;
            repeat (3000) begin
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 11) == 0) b[i] = ~b[i];
                if ($urandom_range(0, 599) == 0)
                    do_reset();
                else
                    step(b, $urandom_range(0, 19) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
